// File: rtl/hram_reset_seq.sv
// HyperRAM power-up reset sequencer: PLL lock, device reset pulse, tVCS wait, SoC reset release.
// Optional button debounce is enabled by defining HRAM_RST_DEBOUNCE_EN.
module hram_reset_seq #(
  parameter int unsigned RST_PULSE_CYC = 200,
  parameter int unsigned VCS_CYC       = 15000,
  parameter int unsigned SOC_RST_CYC   = 16,
  parameter int unsigned DEB_CYC       = 1000000
) (
  input  logic       clkin,
  input  logic       resetn,
  input  logic       pll_locked,
  input  logic       btn_n,
  output logic       hb_reset_n,
  output logic       soc_resetn,
  output logic       ready,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_LOCK   = 3'd0,
    S_HBRST  = 3'd1,
    S_VCS    = 3'd2,
    S_SOCRST = 3'd3,
    S_RUN    = 3'd4
  } state_t;

  // A zero-length phase still lasts one cycle.
  localparam int unsigned P_RST = (RST_PULSE_CYC == 0) ? 1 : RST_PULSE_CYC;
  localparam int unsigned P_VCS = (VCS_CYC == 0) ? 1 : VCS_CYC;
  localparam int unsigned P_SOC = (SOC_RST_CYC == 0) ? 1 : SOC_RST_CYC;
  localparam int unsigned P_M1  = (P_RST > P_VCS) ? P_RST : P_VCS;
  localparam int unsigned P_MAX = (P_M1 > P_SOC) ? P_M1 : P_SOC;
  localparam int          CW    = $clog2(P_MAX) + 1;

  state_t        cur;
  state_t        nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          lock_meta;
  logic          locked_s;
  logic          btn_meta;
  logic          btn_s;
  logic          press;

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      lock_meta <= 1'b0;
      locked_s  <= 1'b0;
      btn_meta  <= 1'b0;
      btn_s     <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      locked_s  <= lock_meta;
      btn_meta  <= btn_n;
      btn_s     <= btn_meta;
    end
  end

`ifdef HRAM_RST_DEBOUNCE_EN
  localparam int unsigned P_DEB = (DEB_CYC == 0) ? 1 : DEB_CYC;
  localparam int          DW    = $clog2(P_DEB) + 1;

  logic [DW-1:0] deb_cnt;
  logic          press_q;

  // Counter saturates at P_DEB; press latches once P_DEB lows are seen.
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      deb_cnt <= '0;
      press_q <= 1'b0;
    end else if (btn_s) begin
      deb_cnt <= '0;
      press_q <= 1'b0;
    end else begin
      if (deb_cnt != DW'(P_DEB)) deb_cnt <= deb_cnt + 1'b1;
      if (deb_cnt >= DW'(P_DEB - 1)) press_q <= 1'b1;
    end
  end

  assign press = press_q;
`else
  assign press = ~btn_s;
`endif

  always_comb begin
    nxt = cur;
    unique case (cur)
      S_LOCK:   if (locked_s && !press) nxt = S_HBRST;
      S_HBRST:  if (cnt == CW'(P_RST - 1)) nxt = S_VCS;
      S_VCS:    if (cnt == CW'(P_VCS - 1)) nxt = S_SOCRST;
      S_SOCRST: if (cnt == CW'(P_SOC - 1)) nxt = S_RUN;
      S_RUN:    nxt = S_RUN;
      default:  nxt = S_LOCK;
    endcase
    if (!locked_s || press) nxt = S_LOCK;
    // Only the timed states count; any state change restarts from zero.
    if (nxt != cur || cur == S_LOCK || cur == S_RUN) cnt_nxt = '0;
    else cnt_nxt = cnt + 1'b1;
  end

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      cur        <= S_LOCK;
      cnt        <= '0;
      hb_reset_n <= 1'b0;
      soc_resetn <= 1'b0;
      ready      <= 1'b0;
    end else begin
      cur        <= nxt;
      cnt        <= cnt_nxt;
      hb_reset_n <= !(nxt == S_LOCK || nxt == S_HBRST);
      soc_resetn <= (nxt == S_RUN);
      ready      <= (nxt == S_RUN);
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_hram_reset_seq.sv
// Directed bench for hram_reset_seq with short phase lengths.
// Edges are counted from resetn release; the first rising edge after it is edge 1.
module tb_hram_reset_seq;

  logic       clkin = 1'b0;
  logic       resetn;
  logic       pll_locked;
  logic       btn_n;
  logic       hb_reset_n;
  logic       soc_resetn;
  logic       ready;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int fin_edge;

  hram_reset_seq #(
    .RST_PULSE_CYC(4),
    .VCS_CYC(10),
    .SOC_RST_CYC(3),
    .DEB_CYC(5)
  ) dut (
    .clkin(clkin),
    .resetn(resetn),
    .pll_locked(pll_locked),
    .btn_n(btn_n),
    .hb_reset_n(hb_reset_n),
    .soc_resetn(soc_resetn),
    .ready(ready),
    .state(state)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    int       e;
    logic [2:0] st;
    logic     hb;
    logic     soc;
    logic     rdy;
  } vec_t;

  vec_t pu[10];

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %0d expected %0d",
               name, edge_n, got, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [2:0] st,
                         input logic hb, input logic soc,
                         input logic rdy);
    chk({name, ".state"}, 32'(state), 32'(st));
    chk({name, ".hb_reset_n"}, 32'(hb_reset_n), 32'(hb));
    chk({name, ".soc_resetn"}, 32'(soc_resetn), 32'(soc));
    chk({name, ".ready"}, 32'(ready), 32'(rdy));
  endtask

  task automatic tick();
    @(posedge clkin);
    #1;
    edge_n++;
  endtask

  task automatic tick_to(input int n);
    while (edge_n < n) tick();
  endtask

  task automatic do_reset(input logic lk);
    resetn     = 1'b0;
    pll_locked = lk;
    btn_n      = 1'b1;
    repeat (3) @(posedge clkin);
    @(negedge clkin);
    resetn = 1'b1;
    edge_n = 0;
  endtask

  initial begin
    pu[0] = '{1, 3'd0, 1'b0, 1'b0, 1'b0};
    pu[1] = '{2, 3'd0, 1'b0, 1'b0, 1'b0};
    pu[2] = '{3, 3'd1, 1'b0, 1'b0, 1'b0};
    pu[3] = '{6, 3'd1, 1'b0, 1'b0, 1'b0};
    pu[4] = '{7, 3'd2, 1'b1, 1'b0, 1'b0};
    pu[5] = '{16, 3'd2, 1'b1, 1'b0, 1'b0};
    pu[6] = '{17, 3'd3, 1'b1, 1'b0, 1'b0};
    pu[7] = '{19, 3'd3, 1'b1, 1'b0, 1'b0};
    pu[8] = '{20, 3'd4, 1'b1, 1'b1, 1'b1};
    pu[9] = '{25, 3'd4, 1'b1, 1'b1, 1'b1};

    // Reset state and power-up sequence
    resetn     = 1'b0;
    pll_locked = 1'b1;
    btn_n      = 1'b1;
    repeat (3) @(posedge clkin);
    #1;
    chk_all("reset", 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clkin);
    resetn = 1'b1;
    edge_n = 0;
    for (int i = 0; i < 10; i++) begin
      tick_to(pu[i].e);
      chk_all("powerup", pu[i].st, pu[i].hb, pu[i].soc, pu[i].rdy);
    end

    // One-cycle lock loss while in the tVCS wait
    do_reset(1'b1);
    tick_to(10);
    chk("lossvcs.pre", 32'(state), 32'd2);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick_to(13);
    chk_all("lossvcs.lock", 3'd0, 1'b0, 1'b0, 1'b0);
    tick_to(14);
    chk("lossvcs.hbrst", 32'(state), 32'd1);
    tick_to(30);
    chk("lossvcs.rdy30", 32'(ready), 32'd0);
    tick_to(31);
    chk_all("lossvcs.run", 3'd4, 1'b1, 1'b1, 1'b1);

    // Late lock: pll_locked sampled high from edge 30
    do_reset(1'b0);
    tick_to(29);
    chk("late.wait", 32'(state), 32'd0);
    pll_locked = 1'b1;
    tick_to(31);
    chk("late.e31", 32'(state), 32'd0);
    tick_to(32);
    chk("late.e32", 32'(state), 32'd1);
    tick_to(48);
    chk("late.rdy48", 32'(ready), 32'd0);
    tick_to(49);
    chk_all("late.run", 3'd4, 1'b1, 1'b1, 1'b1);

`ifdef HRAM_RST_DEBOUNCE_EN
    // Short glitch is filtered
    tick_to(55);
    btn_n = 1'b0;
    tick_to(59);
    btn_n = 1'b1;
    for (int e = 60; e <= 70; e++) begin
      tick_to(e);
      chk("deb.glitch.ready", 32'(ready), 32'd1);
    end
    // Long press forces the restart
    btn_n = 1'b0;
    tick_to(77);
    chk("deb.press.e77", 32'(state), 32'd4);
    tick_to(78);
    chk_all("deb.press.e78", 3'd0, 1'b0, 1'b0, 1'b0);
    btn_n = 1'b1;
    tick_to(81);
    chk("deb.rel.e81", 32'(state), 32'd0);
    tick_to(82);
    chk("deb.rel.e82", 32'(state), 32'd1);
    fin_edge = 99;
`else
    // Undebounced press acts once synchronized
    tick_to(55);
    btn_n = 1'b0;
    tick_to(57);
    chk("btn.e57", 32'(state), 32'd4);
    tick_to(58);
    chk_all("btn.e58", 3'd0, 1'b0, 1'b0, 1'b0);
    tick_to(65);
    chk("btn.hold", 32'(state), 32'd0);
    btn_n = 1'b1;
    tick_to(67);
    chk("btn.rel.e67", 32'(state), 32'd0);
    tick_to(68);
    chk("btn.rel.e68", 32'(state), 32'd1);
    fin_edge = 85;
`endif
    tick_to(fin_edge - 1);
    chk("restart.rdy_pre", 32'(ready), 32'd0);
    tick_to(fin_edge);
    chk_all("restart.run", 3'd4, 1'b1, 1'b1, 1'b1);

    // Asynchronous reset between edges in S_RUN
    tick_to(fin_edge + 2);
    chk("async.pre", 32'(ready), 32'd1);
    @(negedge clkin);
    resetn = 1'b0;
    #1;
    chk_all("async.now", 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("async.hold", 3'd0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
